// File: rtl/write_back_ext.sv
// Write-back stage: registers the incoming result sources and presents one register-file
// write per cycle, splitting a double-precision FPU result into two consecutive beats.
module write_back_ext #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 6,
   parameter int ZERO_REG = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall,
   input  logic [DATA_W-1:0]             NextALUOut,
   input  logic [DATA_W-1:0]             NextMEMDout,
   input  logic [DATA_W-1:0]             NextFPUOutHi,
   input  logic [DATA_W-1:0]             NextFPUOutLo,
   input  logic [DATA_W-1:0]             NextPCPlusFour,
   input  logic [15:0]                   NextImmediate,
   input  logic [2:0]                    NextDInSrc,
   input  logic [2:0]                    NextLoadType,
   input  logic [$clog2(DATA_W/8)-1:0]   NextByteOff,
   input  logic                          NextRegWE,
   input  logic [ADDR_W-1:0]             NextRegWAddr,
   input  logic                          NextDouble,
   output logic                          RegWBWE,
   output logic [ADDR_W-1:0]             RegWBAddr,
   output logic [DATA_W-1:0]             RegWBData,
   output logic                          Busy
);

   localparam int OFF_W = $clog2(DATA_W/8);

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] mem;
      logic [DATA_W-1:0] fpu_hi;
      logic [DATA_W-1:0] fpu_lo;
      logic [DATA_W-1:0] pc4;
      logic [15:0]       imm;
      logic [2:0]        sel;
      logic [2:0]        ltype;
      logic [OFF_W-1:0]  off;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic              dbl;
   } stage_t;

   typedef enum logic {SINGLE = 1'b0, DBL2 = 1'b1} state_t;

   stage_t            stage_q, stage_d;
   state_t            state_q, state_d;
   logic              dbl_write;
   logic [OFF_W-1:0]  byte_idx;
   logic [OFF_W-1:0]  half_idx;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [DATA_W-1:0] load_v;

   always_ff @(posedge clk) begin
      if (!reset) stage_q <= '0;
      else        stage_q <= stage_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= SINGLE;
      else        state_q <= state_d;
   end

   always_comb begin
      stage_d = stage_q;
      if (!stall && !Busy) begin
         stage_d.alu    = NextALUOut;
         stage_d.mem    = NextMEMDout;
         stage_d.fpu_hi = NextFPUOutHi;
         stage_d.fpu_lo = NextFPUOutLo;
         stage_d.pc4    = NextPCPlusFour;
         stage_d.imm    = NextImmediate;
         stage_d.sel    = NextDInSrc;
         stage_d.ltype  = NextLoadType;
         stage_d.off    = NextByteOff;
         stage_d.we     = NextRegWE;
         stage_d.addr   = NextRegWAddr;
         stage_d.dbl    = NextDouble;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!stall) begin
         case (state_q)
            SINGLE:  if (Busy) state_d = DBL2;
            DBL2:    state_d = SINGLE;
            default: state_d = SINGLE;
         endcase
      end
   end

   // Offset 0 names the most significant byte, so the byte index counted from the LSB is ~off.
   always_comb begin
      dbl_write = stage_q.we && stage_q.dbl && (stage_q.sel == 3'd2);
      Busy      = (state_q == SINGLE) && dbl_write;

      byte_idx  = ~stage_q.off;
      half_idx  = {~stage_q.off[OFF_W-1:1], 1'b0};
      byte_v    = 8'(stage_q.mem >> {byte_idx, 3'b000});
      half_v    = 16'(stage_q.mem >> {half_idx, 3'b000});

      case (stage_q.ltype)
         3'd1:    load_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
         3'd2:    load_v = {{(DATA_W-8){1'b0}}, byte_v};
         3'd3:    load_v = {{(DATA_W-16){half_v[15]}}, half_v};
         3'd4:    load_v = {{(DATA_W-16){1'b0}}, half_v};
         default: load_v = stage_q.mem;
      endcase

      RegWBAddr = stage_q.addr;
      if (dbl_write) RegWBAddr[0] = (state_q == DBL2);

      case (stage_q.sel)
         3'd0:    RegWBData = stage_q.pc4;
         3'd1:    RegWBData = stage_q.alu;
         3'd2:    RegWBData = (state_q == DBL2) ? stage_q.fpu_lo : stage_q.fpu_hi;
         3'd3:    RegWBData = load_v;
         3'd4:    RegWBData = {stage_q.imm, {(DATA_W-16){1'b0}}};
         default: RegWBData = '0;
      endcase

      RegWBWE = stage_q.we && (stage_q.sel <= 3'd4);
      if ((ZERO_REG != 0) && (RegWBAddr == '0)) RegWBWE = 1'b0;
   end

endmodule

// File: tb/tb_write_back_ext.sv
// Bench for write_back_ext: directed steps with known answers, then random traffic
// checked every cycle against a transaction-level model of the write-back behaviour.
module tb_write_back_ext;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] pc4;
      logic [15:0] imm;
      logic [2:0]  sel;
      logic [2:0]  ltype;
      logic [1:0]  off;
      logic        we;
      logic [5:0]  addr;
      logic        dbl;
   } tx_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] NextALUOut, NextMEMDout, NextFPUOutHi, NextFPUOutLo, NextPCPlusFour;
   logic [15:0] NextImmediate;
   logic [2:0]  NextDInSrc, NextLoadType;
   logic [1:0]  NextByteOff;
   logic        NextRegWE;
   logic [5:0]  NextRegWAddr;
   logic        NextDouble;
   logic        RegWBWE;
   logic [5:0]  RegWBAddr;
   logic [31:0] RegWBData;
   logic        Busy;

   logic [63:0] mem64 = 64'h0000_0000_0000_8001;
   logic        we64, busy64;
   logic [5:0]  addr64;
   logic [63:0] data64;

   int   total = 0;
   int   bad   = 0;
   tx_t  cur;
   tx_t  mTx;
   bit   mBeat2;

   always #5 clk = ~clk;

   write_back_ext #(.DATA_W(32), .ADDR_W(6), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .NextALUOut(NextALUOut), .NextMEMDout(NextMEMDout),
      .NextFPUOutHi(NextFPUOutHi), .NextFPUOutLo(NextFPUOutLo),
      .NextPCPlusFour(NextPCPlusFour), .NextImmediate(NextImmediate),
      .NextDInSrc(NextDInSrc), .NextLoadType(NextLoadType), .NextByteOff(NextByteOff),
      .NextRegWE(NextRegWE), .NextRegWAddr(NextRegWAddr), .NextDouble(NextDouble),
      .RegWBWE(RegWBWE), .RegWBAddr(RegWBAddr), .RegWBData(RegWBData), .Busy(Busy)
   );

   // Wide build holds one halfword load for the whole run.
   write_back_ext #(.DATA_W(64), .ADDR_W(6), .ZERO_REG(1)) dut64 (
      .clk(clk), .reset(reset), .stall(1'b0),
      .NextALUOut(64'h0), .NextMEMDout(mem64),
      .NextFPUOutHi(64'h0), .NextFPUOutLo(64'h0),
      .NextPCPlusFour(64'h0), .NextImmediate(16'h0),
      .NextDInSrc(3'd3), .NextLoadType(3'd3), .NextByteOff(3'd6),
      .NextRegWE(1'b1), .NextRegWAddr(6'd3), .NextDouble(1'b0),
      .RegWBWE(we64), .RegWBAddr(addr64), .RegWBData(data64), .Busy(busy64)
   );

   function automatic logic [63:0] loadModel(input logic [63:0] mem, input int nb,
                                             input logic [2:0] lt, input int off);
      logic [7:0]  b;
      logic [15:0] h;
      int          ho;
      b  = 8'((mem >> (8 * (nb - 1 - off))) & 64'hFF);
      ho = off - (off % 2);
      h  = 16'((mem >> (8 * (nb - 2 - ho))) & 64'hFFFF);
      case (lt)
         3'd1:    return {{56{b[7]}}, b};
         3'd2:    return {56'h0, b};
         3'd3:    return {{48{h[15]}}, h};
         3'd4:    return {48'h0, h};
         default: return mem;
      endcase
   endfunction

   function automatic bit isDouble();
      return mTx.we && mTx.dbl && (mTx.sel == 3'd2);
   endfunction

   function automatic logic [5:0] expAddr();
      if (!isDouble()) return mTx.addr;
      return mBeat2 ? (mTx.addr | 6'd1) : (mTx.addr & 6'h3E);
   endfunction

   function automatic logic [31:0] expData();
      case (mTx.sel)
         3'd0:    return mTx.pc4;
         3'd1:    return mTx.alu;
         3'd2:    return mBeat2 ? mTx.lo : mTx.hi;
         3'd3:    return 32'(loadModel({32'h0, mTx.mem}, 4, mTx.ltype, int'(mTx.off)));
         3'd4:    return {mTx.imm, 16'h0};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic expWe();
      return mTx.we && (mTx.sel <= 3'd4) && (expAddr() != 6'd0);
   endfunction

   task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, ".we"},   64'(RegWBWE),   64'(expWe()));
      checkOne({tag, ".addr"}, 64'(RegWBAddr), 64'(expAddr()));
      checkOne({tag, ".data"}, 64'(RegWBData), 64'(expData()));
      checkOne({tag, ".busy"}, 64'(Busy),      64'(isDouble() && !mBeat2));
   endtask

   task automatic checkConst(input string tag, input logic we, input logic [5:0] addr,
                             input logic [31:0] data, input logic busy);
      checkOne({tag, ".kwe"},   64'(RegWBWE),   64'(we));
      checkOne({tag, ".kaddr"}, 64'(RegWBAddr), 64'(addr));
      checkOne({tag, ".kdata"}, 64'(RegWBData), 64'(data));
      checkOne({tag, ".kbusy"}, 64'(Busy),      64'(busy));
   endtask

   task automatic applyStimulus(input tx_t s);
      cur            = s;
      NextALUOut     = s.alu;
      NextMEMDout    = s.mem;
      NextFPUOutHi   = s.hi;
      NextFPUOutLo   = s.lo;
      NextPCPlusFour = s.pc4;
      NextImmediate  = s.imm;
      NextDInSrc     = s.sel;
      NextLoadType   = s.ltype;
      NextByteOff    = s.off;
      NextRegWE      = s.we;
      NextRegWAddr   = s.addr;
      NextDouble     = s.dbl;
   endtask

   // A doubled FP write occupies two cycles; anything else is taken as soon as the stage is free.
   task automatic tick();
      if (!reset) begin
         mTx    = '0;
         mBeat2 = 1'b0;
      end else if (!stall) begin
         if (isDouble() && !mBeat2) begin
            mBeat2 = 1'b1;
         end else begin
            mBeat2 = 1'b0;
            mTx    = cur;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic tx_t randTx();
      tx_t t;
      t.alu   = $urandom;
      t.mem   = $urandom;
      t.hi    = $urandom;
      t.lo    = $urandom;
      t.pc4   = $urandom;
      t.imm   = 16'($urandom);
      t.sel   = 3'($urandom_range(0, 7));
      t.ltype = 3'($urandom_range(0, 7));
      t.off   = 2'($urandom_range(0, 3));
      t.we    = ($urandom_range(0, 4) != 0);
      t.addr  = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 1)) : 6'($urandom);
      t.dbl   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
         t.sel = 3'd2;
         t.dbl = 1'b1;
      end
      return t;
   endfunction

   initial begin
      tx_t s;
      mTx    = '0;
      mBeat2 = 1'b0;
      reset  = 1'b0;
      stall  = 1'b0;
      applyStimulus('0);
      tick();
      tick();
      checkConst("reset", 1'b0, 6'd0, 32'h0, 1'b0);
      reset = 1'b1;
      tick();
      checkOutput("idle");
      checkConst("idle", 1'b0, 6'd0, 32'h0, 1'b0);

      s = '0; s.sel = 3'd1; s.alu = 32'h1234_5678; s.addr = 6'd5; s.we = 1'b1;
      applyStimulus(s); tick();
      checkOutput("alu"); checkConst("alu", 1'b1, 6'd5, 32'h1234_5678, 1'b0);

      s.sel = 3'd3; s.ltype = 3'd1; s.mem = 32'h80FF_0000; s.off = 2'd0;
      applyStimulus(s); tick();
      checkOutput("lbs"); checkConst("lbs", 1'b1, 6'd5, 32'hFFFF_FF80, 1'b0);

      s.ltype = 3'd2; s.off = 2'd1;
      applyStimulus(s); tick();
      checkOutput("lbu"); checkConst("lbu", 1'b1, 6'd5, 32'h0000_00FF, 1'b0);

      s = '0; s.sel = 3'd2; s.dbl = 1'b1; s.we = 1'b1; s.addr = 6'h23;
      s.hi = 32'hAAAA_0000; s.lo = 32'h5555_FFFF;
      applyStimulus(s); tick();
      checkOutput("dbl1"); checkConst("dbl1", 1'b1, 6'h22, 32'hAAAA_0000, 1'b1);
      s = '0; s.sel = 3'd1; s.alu = 32'h1111_1111; s.addr = 6'd9; s.we = 1'b1;
      applyStimulus(s); tick();
      checkOutput("dbl2"); checkConst("dbl2", 1'b1, 6'h23, 32'h5555_FFFF, 1'b0);
      tick();
      checkOutput("after"); checkConst("after", 1'b1, 6'd9, 32'h1111_1111, 1'b0);

      s = '0; s.sel = 3'd4; s.imm = 16'hBEEF; s.addr = 6'd0; s.we = 1'b1;
      applyStimulus(s); tick();
      checkOutput("lhi0"); checkConst("lhi0", 1'b0, 6'd0, 32'hBEEF_0000, 1'b0);
      s.addr = 6'd7;
      applyStimulus(s); tick();
      checkOutput("lhi7"); checkConst("lhi7", 1'b1, 6'd7, 32'hBEEF_0000, 1'b0);

      s = '0; s.sel = 3'd2; s.dbl = 1'b1; s.we = 1'b1; s.addr = 6'h11;
      s.hi = 32'hCAFE_0001; s.lo = 32'hCAFE_0002;
      applyStimulus(s); tick();
      checkConst("sb1", 1'b1, 6'h10, 32'hCAFE_0001, 1'b1);
      tick();
      checkConst("sb2", 1'b1, 6'h11, 32'hCAFE_0002, 1'b0);
      stall = 1'b1;
      applyStimulus(randTx());
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall");
         checkConst("stall", 1'b1, 6'h11, 32'hCAFE_0002, 1'b0);
      end
      stall = 1'b0;
      s = '0; s.sel = 3'd0; s.pc4 = 32'h0000_1004; s.addr = 6'd31; s.we = 1'b1;
      applyStimulus(s); tick();
      checkOutput("unstall"); checkConst("unstall", 1'b1, 6'd31, 32'h0000_1004, 1'b0);

      s = '0; s.sel = 3'd2; s.dbl = 1'b1; s.we = 1'b1; s.addr = 6'h05;
      s.hi = 32'h0BAD_0001; s.lo = 32'h0BAD_0002;
      applyStimulus(s); tick();
      checkOutput("rb1");
      tick();
      checkOutput("rb2");
      reset = 1'b0;
      tick();
      checkOutput("rstdbl"); checkConst("rstdbl", 1'b0, 6'd0, 32'h0, 1'b0);
      reset = 1'b1;
      applyStimulus('0);
      tick();

      checkOne("w64.data", data64, 64'hFFFF_FFFF_FFFF_8001);
      checkOne("w64.we",   64'(we64), 64'd1);
      checkOne("w64.addr", 64'(addr64), 64'd3);
      checkOne("w64.busy", 64'(busy64), 64'd0);

      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 39) != 0);
         stall = ($urandom_range(0, 4) == 0);
         applyStimulus(randTx());
         tick();
         checkOutput("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/write_back_ext.md
WRITE_BACK_EXT -- requirements
Module: write_back_ext

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 6, register-file address width.
REQ-003 SHALL have parameter ZERO_REG, default 1, suppresses writes to address 0 when 1.
REQ-004 SHALL have ports: clk  in  1  clock; one clock, all state on rising edge of clk.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port stall  in  1  hold all state.
REQ-007 SHALL have ports NextALUOut, NextMEMDout, NextFPUOutHi, NextFPUOutLo  in  DATA_W each  result sources.
REQ-008 SHALL have port NextPCPlusFour  in  DATA_W  link value.
REQ-009 SHALL have port NextImmediate  in  16  LHI immediate.
REQ-010 SHALL have port NextDInSrc  in  3  source select.
REQ-011 SHALL have port NextLoadType  in  3  load extract mode.
REQ-012 SHALL have port NextByteOff  in  log2(DATA_W/8)  load byte offset.
REQ-013 SHALL have ports NextRegWE  in  1, NextRegWAddr  in  ADDR_W, NextDouble  in  1  double-precision FP write.
REQ-014 SHALL have outputs RegWBWE  out  1, RegWBAddr  out  ADDR_W, RegWBData  out  DATA_W, Busy  out  1  upstream hold request.

Function
REQ-015 All Next* inputs SHALL be captured into a stage register on a clk edge when reset=1, stall=0, Busy=0; otherwise the stage register holds.
REQ-016 State machine SHALL have states SINGLE and DBL2; SINGLE after reset.
REQ-017 Busy SHALL be 1 exactly when state=SINGLE and captured RegWE=1, Double=1, DInSrc=2; combinational from the stage register and state.
REQ-018 SINGLE->DBL2 SHALL occur on an edge with Busy=1 and stall=0; DBL2->SINGLE SHALL occur on the next edge with stall=0; stall=1 freezes state.
REQ-019 Select decode: 0 PC+4; 1 ALU; 2 FPU (Hi in SINGLE, Lo in DBL2); 3 extracted memory data; 4 {Immediate, DATA_W-16 zeros}; 5-7 data 0 with RegWBWE forced 0.
REQ-020 Load extract, offset 0 = most significant byte: 0 full word; 1 byte sign-extended; 2 byte zero-extended; 3 halfword sign-extended; 4 halfword zero-extended; 5-7 full word.
REQ-021 Halfword offset SHALL use offset with LSB ignored; wrong alignment is not flagged.
REQ-022 Double write: beat 1 (SINGLE) address = captured address with LSB cleared; beat 2 (DBL2) address = LSB set; RegWBWE=1 on both beats.
REQ-023 NextDouble with select other than 2 or RegWE=0 SHALL act as a single write with no DBL2 beat.
REQ-024 RegWBWE SHALL equal captured RegWE, ANDed with select<=4, and with address!=0 when ZERO_REG=1 (checked per beat).
REQ-025 Outputs SHALL be combinational from stage register and state; latency one edge from capture to write presentation.
REQ-026 While stall=1 outputs SHALL stay constant, including RegWBWE; repeated identical writes are permitted.

Reset
REQ-027 On an edge with reset=0: stage register cleared to zero, state=SINGLE, regardless of stall or state.
REQ-028 After reset: RegWBWE=0, RegWBAddr=0, RegWBData=0, Busy=0.
REQ-029 Reset during DBL2 SHALL abandon beat 2 with no further write.

Verification
REQ-030 Reset then idle -> RegWBWE=0, RegWBAddr=0, RegWBData=0, Busy=0.
REQ-031 Sel=1, ALU=0x12345678, addr=5, WE=1 -> next cycle RegWBWE=1, Addr=5, Data=0x12345678; sel=3, type=1, MEM=0x80FF0000, off=0 -> Data=0xFFFFFF80; type=2, off=1 -> Data=0x000000FF.
REQ-032 Sel=2, Double=1, addr=0x23, Hi=0xAAAA0000, Lo=0x5555FFFF -> cycle 1 Addr=0x22, Data=0xAAAA0000, Busy=1; cycle 2 Addr=0x23, Data=0x5555FFFF, Busy=0; new input captured only at end of cycle 2.
REQ-033 Sel=4, Imm=0xBEEF, addr=0 with ZERO_REG=1 -> RegWBWE=0; addr=7 -> Data=0xBEEF0000, RegWBWE=1.
REQ-034 Stall=1 for 3 cycles during DBL2 -> Addr/Data/WE held 3 cycles, then SINGLE; reset=0 during DBL2 -> next cycle all outputs 0.
REQ-035 DATA_W=64 build, type=3, off=6, MEM=0x0000000000008001 -> Data=0xFFFFFFFFFFFF8001.
